// File: rtl/halton_fsm_stream_nd_if.sv
// halton_fsm_stream_nd_if: control inputs and point stream of the Halton generator.
interface halton_fsm_stream_nd_if #(
    parameter int NUM_DIM = 2,
    parameter int OUT_W   = 32
);
    logic                     clear;
    logic [2*NUM_DIM-1:0]     base_sel;
    logic                     run;
    logic                     out_valid;
    logic                     out_ready;
    logic [NUM_DIM*OUT_W-1:0] out_data;
    logic [OUT_W-1:0]         out_index;
    logic                     busy;
    logic                     wrapped;
    modport master (
        input  clear, base_sel, run, out_ready,
        output out_valid, out_data, out_index, busy, wrapped
    );
    modport slave (
        output clear, base_sel, run, out_ready,
        input  out_valid, out_data, out_index, busy, wrapped
    );
endinterface

// File: rtl/halton_fsm_stream_nd.sv
// halton_fsm_stream_nd: streaming N-lane Halton generator, per-lane base-b odometer rebuilt digit-serially.
module halton_fsm_stream_nd #(
    parameter int NUM_DIM = 2,
    parameter int OUT_W   = 32,
    parameter int NDIG    = OUT_W
) (
    input logic clk,
    input logic rst,
    halton_fsm_stream_nd_if.master s
);
    localparam int PW = NDIG > 1 ? $clog2(NDIG) : 1;
    typedef enum logic [1:0] {IDLE, INCR, ACCUM, HOLD} state_t;
    state_t state, state_nx;
    logic             run_q;
    logic [PW-1:0]    ptr;
    logic [OUT_W-1:0] index;
    logic [1:0]       code   [NUM_DIM];
    logic [2:0]       bv     [NUM_DIM];
    logic [2:0]       dig    [NUM_DIM][NDIG];
    logic [2:0]       dig_nx [NUM_DIM][NDIG];
    logic [2:0]       dsel   [NUM_DIM];
    logic [OUT_W-1:0] rsel   [NUM_DIM];
    logic [OUT_W-1:0] term   [NUM_DIM];
    logic [OUT_W-1:0] acc    [NUM_DIM];
    logic [OUT_W-1:0] rt     [4][NDIG];
    logic             restart, last, take;
    assign restart = rst || s.clear;
    assign last    = ptr == PW'(NDIG - 1);
    assign take    = s.out_valid && s.out_ready;
    function automatic logic [OUT_W-1:0] r_const(input int b, input int i);
        longint unsigned p;
        longint unsigned full;
        p    = 64'd1;
        full = 64'd1 << OUT_W;
        for (int j = 0; j <= i; j++) begin
            p = p * 64'(b);
            if (p > full) return '0;
        end
        return OUT_W'(full / p);
    endfunction
    // weight table floor(2^OUT_W / b^(i+1)) for each of the four base codes
    for (genvar c = 0; c < 4; c++) begin : g_rt
        for (genvar i = 0; i < NDIG; i++) begin : g_i
            localparam logic [OUT_W-1:0] R = r_const(c == 0 ? 2 : c == 1 ? 3 : c == 2 ? 5 : 7, i);
            assign rt[c][i] = R;
        end
    end
    always_comb begin
        logic c;
        c = 1'b0;
        for (int d = 0; d < NUM_DIM; d++) begin
            bv[d] = code[d] == 2'd0 ? 3'd2 : code[d] == 2'd1 ? 3'd3 : code[d] == 2'd2 ? 3'd5 : 3'd7;
            c = 1'b1;
            for (int j = 0; j < NDIG; j++) begin
                dig_nx[d][j] = (c && dig[d][j] == bv[d] - 3'd1) ? 3'd0 : dig[d][j] + {2'b00, c};
                c = c && dig[d][j] == bv[d] - 3'd1;
            end
            dsel[d] = dig[d][ptr];
            rsel[d] = rt[code[d]][ptr];
            // digits never exceed 6, so three conditional shifted adds replace a multiplier
            term[d] = (dsel[d][0] ? rsel[d] : '0) + (dsel[d][1] ? rsel[d] << 1 : '0)
                    + (dsel[d][2] ? rsel[d] << 2 : '0);
        end
    end
    always_ff @(posedge clk) state <= restart ? IDLE : state_nx;
    always_comb begin
        state_nx = state;
        s.busy   = 1'b0;
        case (state)
            IDLE:    state_nx = run_q ? INCR : IDLE;
            INCR:    begin state_nx = ACCUM; s.busy = 1'b1; end
            ACCUM:   begin state_nx = last ? HOLD : ACCUM; s.busy = 1'b1; end
            default: state_nx = take ? (s.run ? INCR : IDLE) : HOLD;
        endcase
    end
    // run is registered in IDLE only, so the first point lands NDIG+2 edges after run is seen
    always_ff @(posedge clk) begin
        if (restart) begin
            run_q       <= 1'b0;
            ptr         <= '0;
            index       <= '0;
            s.out_valid <= 1'b0;
            s.out_data  <= '0;
            s.out_index <= '0;
            s.wrapped   <= 1'b0;
            for (int d = 0; d < NUM_DIM; d++) begin
                code[d] <= s.base_sel[2*d +: 2];
                acc[d]  <= '0;
                for (int j = 0; j < NDIG; j++) dig[d][j] <= 3'd0;
            end
        end else begin
            run_q <= s.run && state == IDLE;
            if (state == INCR) begin
                index <= index + 1'b1;
                ptr   <= '0;
                if (&index) s.wrapped <= 1'b1;
                for (int d = 0; d < NUM_DIM; d++) begin
                    acc[d] <= '0;
                    for (int j = 0; j < NDIG; j++) dig[d][j] <= dig_nx[d][j];
                end
            end
            if (state == ACCUM) begin
                ptr <= ptr + 1'b1;
                for (int d = 0; d < NUM_DIM; d++) acc[d] <= acc[d] + term[d];
                if (last) begin
                    s.out_valid <= 1'b1;
                    s.out_index <= index;
                    for (int d = 0; d < NUM_DIM; d++) s.out_data[d*OUT_W +: OUT_W] <= acc[d] + term[d];
                end
            end
            if (state == HOLD && take) s.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_halton_fsm_stream_nd.sv
// tb_halton_fsm_stream_nd: scoreboard bench for the Halton stream generator (32-bit 2-lane and 8-bit wrap instances).
module tb_halton_fsm_stream_nd;
    logic clk = 1'b0;
    logic rst, rst2;
    int   checks = 0, errors = 0, got = 0, cnt2 = 0, n;
    typedef struct {
        logic [63:0] data;
        logic [31:0] idx;
    } exp_t;
    exp_t        sb[$];
    exp_t        e;
    logic        stall_prev = 1'b0;
    logic [63:0] held_data;
    logic [31:0] held_idx;
    logic [7:0]  k8, exp8;

    halton_fsm_stream_nd_if #(.NUM_DIM(2), .OUT_W(32)) m ();
    halton_fsm_stream_nd #(.NUM_DIM(2), .OUT_W(32)) dut (.clk(clk), .rst(rst), .s(m));
    halton_fsm_stream_nd_if #(.NUM_DIM(1), .OUT_W(8)) w ();
    halton_fsm_stream_nd #(.NUM_DIM(1), .OUT_W(8)) dut8 (.clk(clk), .rst(rst2), .s(w));

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic wait_cnt(input int which, input int k);
        int t;
        t = 0;
        while ((which == 0 ? got : cnt2) < k && t < 4000) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk(which == 0 ? "points_seen" : "wrap_points_seen", 64'((which == 0 ? got : cnt2) >= k), 64'd1);
    endtask

    // scoreboard monitor for the 32-bit instance, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst && !m.clear) begin
            if (m.out_valid && stall_prev) begin
                chk("hold_data", m.out_data, held_data);
                chk("hold_index", 64'(m.out_index), 64'(held_idx));
                chk("hold_no_incr", 64'(m.busy), 64'd0);
            end
            if (m.out_valid && m.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_point: got index %0d expected none", m.out_index);
                end else begin
                    e = sb.pop_front();
                    chk("point_data", m.out_data, e.data);
                    chk("point_index", 64'(m.out_index), 64'(e.idx));
                    chk("point_wrapped", 64'(m.wrapped), 64'd0);
                end
                got++;
            end
            stall_prev = m.out_valid && !m.out_ready;
            held_data  = m.out_data;
            held_idx   = m.out_index;
        end else stall_prev = 1'b0;
    end

    // 8-bit base-2 instance: point k is the bit reversal of k mod 256
    always @(negedge clk) begin
        if (rst2) cnt2 = 0;
        else if (w.out_valid && w.out_ready) begin
            cnt2++;
            k8 = 8'(cnt2);
            for (int i = 0; i < 8; i++) exp8[i] = k8[7-i];
            chk("wrap_index", 64'(w.out_index), 64'(k8));
            chk("wrap_data", 64'(w.out_data), 64'(exp8));
            chk("wrap_flag", 64'(w.wrapped), 64'(cnt2 >= 256));
        end
    end

    initial begin
        rst = 1'b1;
        rst2 = 1'b1;
        m.clear = 1'b0;
        m.run = 1'b0;
        m.out_ready = 1'b0;
        m.base_sel = 4'b0100;
        w.clear = 1'b0;
        w.run = 1'b0;
        w.out_ready = 1'b0;
        w.base_sel = 2'b00;
        cyc(3);
        rst = 1'b0;
        rst2 = 1'b0;
        chk("rst_valid", 64'(m.out_valid), 64'd0);
        chk("rst_data", m.out_data, 64'd0);
        chk("rst_index", 64'(m.out_index), 64'd0);
        chk("rst_busy", 64'(m.busy), 64'd0);
        chk("rst_wrapped", 64'(m.wrapped), 64'd0);
        // bases 2 and 3, three consecutive points, latency from run sample
        sb.push_back('{64'h55555555_80000000, 32'd1});
        sb.push_back('{64'hAAAAAAAA_40000000, 32'd2});
        sb.push_back('{64'h1C71C71C_C0000000, 32'd3});
        m.out_ready = 1'b1;
        m.run = 1'b1;
        @(posedge clk);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (!m.out_valid && n < 100);
        chk("latency", 64'(n), 64'd34);
        wait_cnt(0, 2);
        m.run = 1'b0;
        wait_cnt(0, 3);
        cyc(50);
        chk("idle_valid", 64'(m.out_valid), 64'd0);
        chk("idle_busy", 64'(m.busy), 64'd0);
        // bases 5 and 7, run pulsed for one cycle gives exactly one point
        m.clear = 1'b1;
        m.base_sel = 4'b1110;
        cyc(1);
        m.clear = 1'b0;
        sb.push_back('{64'h24924924_33333333, 32'd1});
        m.run = 1'b1;
        cyc(1);
        m.run = 1'b0;
        wait_cnt(0, 4);
        cyc(50);
        chk("pulse_idle_valid", 64'(m.out_valid), 64'd0);
        chk("pulse_idle_busy", 64'(m.busy), 64'd0);
        // backpressure: 20 stalled cycles, then a single accept
        m.clear = 1'b1;
        m.base_sel = 4'b0100;
        cyc(1);
        m.clear = 1'b0;
        m.out_ready = 1'b0;
        sb.push_back('{64'h55555555_80000000, 32'd1});
        sb.push_back('{64'hAAAAAAAA_40000000, 32'd2});
        m.run = 1'b1;
        n = 0;
        while (!m.out_valid && n < 100) begin
            cyc(1);
            n++;
        end
        chk("bp_valid", 64'(m.out_valid), 64'd1);
        cyc(20);
        m.out_ready = 1'b1;
        cyc(1);
        m.out_ready = 1'b0;
        m.run = 1'b0;
        n = 0;
        while (!m.out_valid && n < 100) begin
            cyc(1);
            n++;
        end
        chk("bp_next_valid", 64'(m.out_valid), 64'd1);
        m.out_ready = 1'b1;
        wait_cnt(0, 6);
        // clear mid-ACCUM with new bases 7 and 2
        m.run = 1'b1;
        cyc(10);
        m.run = 1'b0;
        chk("accum_busy", 64'(m.busy), 64'd1);
        m.clear = 1'b1;
        m.base_sel = 4'b0011;
        cyc(1);
        m.clear = 1'b0;
        chk("clr_valid", 64'(m.out_valid), 64'd0);
        chk("clr_busy", 64'(m.busy), 64'd0);
        chk("clr_data", m.out_data, 64'd0);
        chk("clr_index", 64'(m.out_index), 64'd0);
        cyc(40);
        chk("clr_no_point", 64'(m.out_valid), 64'd0);
        sb.push_back('{64'h80000000_24924924, 32'd1});
        m.run = 1'b1;
        cyc(1);
        m.run = 1'b0;
        wait_cnt(0, 7);
        cyc(20);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        // 8-bit index wrap on base 2
        w.out_ready = 1'b1;
        w.run = 1'b1;
        wait_cnt(1, 256);
        w.run = 1'b0;
        wait_cnt(1, 257);
        cyc(20);
        chk("wrap_sticky", 64'(w.wrapped), 64'd1);
        rst2 = 1'b1;
        cyc(1);
        rst2 = 1'b0;
        chk("wrap_rst_clear", 64'(w.wrapped), 64'd0);
        chk("wrap_rst_valid", 64'(w.out_valid), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
